// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - Shared constants, FSM state and op-select types for the Montgomery sequencer
package mont_pkg;
    localparam int               WIDTH   = 64;
    localparam logic [WIDTH-1:0] N_MOD   = 64'hFFFF_FFFF_FFFF_FFF1;
    localparam logic [WIDTH-1:0] R2_MOD  = 64'd225;
    localparam int               TIMEOUT = 1024;
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_A   = 3'd1,
        ST_CONV_B   = 3'd2,
        ST_MUL      = 3'd3,
        ST_CONV_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_CONV_A   = 2'd0,
        OP_CONV_B   = 2'd1,
        OP_MUL      = 2'd2,
        OP_CONV_OUT = 2'd3
    } op_e;

    localparam logic PH_ISSUE = 1'b0;
    localparam logic PH_WAIT  = 1'b1;
endpackage

// File: rtl/mont_op_mux.sv
// rtl/mont_op_mux.sv - Selects REDC engine operands for the current op
// MONT_SEQ_SHORTCUT_EN: MUL multiplies a_bar by plain b, folding the output conversion in.
module mont_op_mux
    import mont_pkg::*;
(
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] a_bar_i,
    input  logic [WIDTH-1:0] b_bar_i,
    input  logic [WIDTH-1:0] c_bar_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o
);
`ifdef MONT_SEQ_SHORTCUT_EN
    logic unused_b_bar;
    assign unused_b_bar = ^b_bar_i;
`endif

    always_comb begin
        op_a_o = '0;
        op_b_o = '0;
        case (op_i)
            OP_CONV_A: begin
                op_a_o = a_i;
                op_b_o = R2_MOD;
            end
            OP_CONV_B: begin
                op_a_o = b_i;
                op_b_o = R2_MOD;
            end
            OP_MUL: begin
                op_a_o = a_bar_i;
`ifdef MONT_SEQ_SHORTCUT_EN
                op_b_o = b_i;
`else
                op_b_o = b_bar_i;
`endif
            end
            default: begin
                op_a_o = c_bar_i;
                op_b_o = WIDTH'(1);
            end
        endcase
    end
endmodule

// File: rtl/mont_mul_sequencer.sv
// rtl/mont_mul_sequencer.sv - Sequences (a*b) mod N through a shared REDC engine
// MONT_SEQ_SHORTCUT_EN selects the two-op chain REDC(REDC(a, R^2), b).
module mont_mul_sequencer
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mm_req_valid,
    input  logic             mm_req_ready,
    output logic [WIDTH-1:0] mm_op_a,
    output logic [WIDTH-1:0] mm_op_b,
    input  logic             mm_rsp_valid,
    input  logic [WIDTH-1:0] mm_rsp_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);
    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] a_bar_q, a_bar_d, b_bar_q, b_bar_d, c_bar_q, c_bar_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             op_state, rsp_take;
    logic [WIDTH-1:0] mux_a, mux_b;
    op_e              op;

    assign op_state     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign mm_req_valid = op_state && (phase_q == PH_ISSUE);
    assign rsp_take     = op_state && (phase_q == PH_WAIT) && mm_rsp_valid;
    assign mm_op_a      = mm_req_valid ? mux_a : '0;
    assign mm_op_b      = mm_req_valid ? mux_b : '0;
    assign in_ready     = (state_q == ST_IDLE);
    assign res_valid    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign res_data     = res_q;
    assign res_err      = err_q;

    always_comb begin
        case (state_q)
            ST_CONV_B:   op = OP_CONV_B;
            ST_MUL:      op = OP_MUL;
            ST_CONV_OUT: op = OP_CONV_OUT;
            default:     op = OP_CONV_A;
        endcase
    end

    mont_op_mux u_op_mux (
        .op_i    (op),
        .a_i     (a_q),
        .b_i     (b_q),
        .a_bar_i (a_bar_q),
        .b_bar_i (b_bar_q),
        .c_bar_i (c_bar_q),
        .op_a_o  (mux_a),
        .op_b_o  (mux_b)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        a_bar_d = a_bar_q;
        b_bar_d = b_bar_q;
        c_bar_d = c_bar_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    phase_d = PH_ISSUE;
                    cnt_d   = '0;
                    if ((in_a >= N_MOD) || (in_b >= N_MOD)) begin
                        state_d = ST_DONE;
                        res_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_CONV_A;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: begin
                // A response landing on the final budget cycle still wins over the timeout.
                if (rsp_take) begin
                    phase_d = PH_ISSUE;
                    cnt_d   = '0;
                    case (state_q)
                        ST_CONV_A: begin
                            a_bar_d = mm_rsp_data;
`ifdef MONT_SEQ_SHORTCUT_EN
                            state_d = ST_MUL;
`else
                            state_d = ST_CONV_B;
`endif
                        end
                        ST_CONV_B: begin
                            b_bar_d = mm_rsp_data;
                            state_d = ST_MUL;
                        end
                        ST_MUL: begin
                            c_bar_d = mm_rsp_data;
`ifdef MONT_SEQ_SHORTCUT_EN
                            res_d   = mm_rsp_data;
                            state_d = ST_DONE;
`else
                            state_d = ST_CONV_OUT;
`endif
                        end
                        default: begin
                            res_d   = mm_rsp_data;
                            state_d = ST_DONE;
                        end
                    endcase
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    res_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((phase_q == PH_ISSUE) && mm_req_ready) phase_d = PH_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_bar_q <= '0;
            b_bar_q <= '0;
            c_bar_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_bar_q <= a_bar_d;
            b_bar_q <= b_bar_d;
            c_bar_q <= c_bar_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/mont_mul_sequencer.md
# mont_mul_sequencer

Sequences one full modular multiplication, (a·b) mod N, through a shared Montgomery multiply-reduce unit (REDC engine). It accepts an operand pair over a valid/ready handshake and range-checks it. It then issues the chain of Montgomery operations to the engine over a request/response port, holds the intermediates, and returns the result or an error over a second valid/ready handshake. It sits between the operand source and the REDC datapath, and is the only requester of that engine.

## Interface
- WIDTH, 64: operand/radix width; R = 2^WIDTH
- N_MOD, 64'hFFFF_FFFF_FFFF_FFF1: odd modulus
- R2_MOD, 64'd225: R² mod N for the default N_MOD
- TIMEOUT, 1024: max cycles per engine operation before abort
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept
- in_a, in_b  in  WIDTH  operands, must be < N_MOD
- mm_req_valid  out  1  engine request valid
- mm_req_ready  in  1  engine accepts request
- mm_op_a, mm_op_b  out  WIDTH  engine operands; engine returns REDC(op_a·op_b) = op_a·op_b·R⁻¹ mod N
- mm_rsp_valid  in  1  engine result valid, one-cycle pulse
- mm_rsp_data  in  WIDTH  engine result
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  (a·b) mod N, or 0 on error
- res_err  out  1  1 = range error or timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CONV_A, CONV_B, MUL, CONV_OUT, DONE.
- Each op state has two phases: ISSUE, then WAIT.
- IDLE: in_ready=1. On in_valid, a and b are latched.
  - If a ≥ N_MOD or b ≥ N_MOD: go to DONE with res_err=1, res_data=0, no engine request.
  - Otherwise: go to CONV_A.
- Op chain, each REDC(x,y):
  - CONV_A: a_bar = REDC(a, R2_MOD)
  - CONV_B: b_bar = REDC(b, R2_MOD)
  - MUL: c_bar = REDC(a_bar, b_bar)
  - CONV_OUT: c = REDC(c_bar, 1)
- ISSUE: mm_req_valid=1 with operands stable until mm_req_ready. On handshake, go to WAIT.
- WAIT: on mm_rsp_valid, capture mm_rsp_data and advance to the next op state. After CONV_OUT, go to DONE.
- mm_rsp_valid outside WAIT is ignored.
- DONE: res_valid=1, res_data/res_err held stable until res_ready. Then go to IDLE.
- Timeout:
  - A cycle counter clears on entry to each op state and counts ISSUE and WAIT cycles.
  - If it reaches TIMEOUT: go to DONE, res_err=1, res_data=0.
  - Any late engine response is ignored.
- The engine result is trusted to be < N; no final subtraction is done here.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1 in the first cycle after reset is released.
  - mm_req_valid=0, res_valid=0, res_err=0, busy=0.
  - res_data, mm_op_a, mm_op_b = 0.
  - Timeout counter = 0.
- Accept at cycle 0 → first mm_req_valid at cycle 1.
- Response captured at cycle k → next request at cycle k+1.
- Best case (engine ready immediately, 1-cycle response):
  - Requests at cycles 1, 3, 5, 7.
  - res_valid at cycle 9.
- Range error: res_valid at cycle 1.
- res_ready at cycle d → in_ready at d+1. There is no accept/complete overlap: one transaction in flight.
- rst mid-operation: return to IDLE next cycle and drop the transaction. The engine is reset by the same rst.

## Configuration
- MONT_SEQ_SHORTCUT_EN defined: two-op chain.
  - a_bar = REDC(a, R2_MOD), then c = REDC(a_bar, b).
  - CONV_B and CONV_OUT are skipped.
  - Best-case res_valid at cycle 5.
- MONT_SEQ_SHORTCUT_EN not defined: the full four-op chain above.
- Results are identical in both builds.

## Structure
- Package mont_pkg:
  - State enum.
  - WIDTH, N_MOD, R2_MOD, TIMEOUT defaults.
  - Op-select enum (OP_CONV_A, OP_CONV_B, OP_MUL, OP_CONV_OUT).
- One sub-module: mont_op_mux, combinational.
  - Maps the current op plus the latched a, b, a_bar, b_bar, c_bar to mm_op_a and mm_op_b.
- FSM, timeout counter and registers live in mont_mul_sequencer.

## Test plan
- a=2, b=3, ideal engine model → res_data=6, res_err=0; four requests; res_valid at cycle 9.
- a=N−1, b=N−1 → res_data=1. Engine mm_req_ready low for 5 cycles per op → operands held stable throughout.
- a=N_MOD, b=5 → res_valid at cycle 1, res_err=1, res_data=0, zero engine requests.
- Engine never responds in MUL → res_err=1, res_data=0 after TIMEOUT cycles in MUL; late mm_rsp_valid ignored; next transaction correct.
- res_ready low 10 cycles → res_valid/res_data stable, in_ready=0 throughout. rst asserted during CONV_B → IDLE next cycle, no res_valid.
- With MONT_SEQ_SHORTCUT_EN: a=7, b=11 → res_data=77, two requests, res_valid at cycle 5.
